// File: rtl/bus_slave_bram.sv
// Serial-bus slave in front of an inferred block RAM: bit-serial address, burst, write and read data.
// Define SLAVE_SPLIT_EN to drive s_split_en during long read waits; otherwise it is tied low.
`timescale 1ns/1ps
module bus_slave_bram #(
    parameter int ADDR_LEN        = 12,
    parameter int DATA_LEN        = 8,
    parameter int BURST_LEN       = 12,
    parameter int SPLIT_THRESHOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_master_valid,
    input  logic       s_master_ready,
    input  logic       s_write_en,
    input  logic       s_read_en,
    input  logic       s_rx_address,
    input  logic       s_rx_burst,
    input  logic       s_rx_data,
    input  logic [5:0] s_slave_delay,
    output logic       s_slave_ready,
    output logic       s_slave_valid,
    output logic       s_tx_data,
    output logic       s_split_en
);

    localparam int            MAX_LEN   = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int            CW        = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);

    if (BURST_LEN != ADDR_LEN) begin : g_bad_burst_len
        $error("BURST_LEN must equal ADDR_LEN");
    end
    if (SPLIT_THRESHOLD < 0 || SPLIT_THRESHOLD > 63) begin : g_bad_threshold
        $error("SPLIT_THRESHOLD must fit the 6-bit delay range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_WAIT, S_FETCH, S_RDATA
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_LEN-1:0]    addr_q, addr_d;
    logic [BURST_LEN-1:0]   burst_q, burst_d;
    logic [BURST_LEN-1:0]   remain_q, remain_d;
    logic [DATA_LEN-1:0]    data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [5:0]             delay_q, delay_d;
    logic [5:0]             wait_cnt_q, wait_cnt_d;
    logic                   is_read_q, is_read_d;

    logic [DATA_LEN-1:0]    mem [2**ADDR_LEN];
    logic [DATA_LEN-1:0]    rd_data_q;

    logic                   accept;
    logic [ADDR_LEN-1:0]    addr_shift;
    logic [BURST_LEN-1:0]   burst_shift;

    assign accept      = (state_q == S_IDLE) && s_master_valid && (s_write_en ^ s_read_en);
    assign addr_shift  = {s_rx_address, addr_q[ADDR_LEN-1:1]};
    assign burst_shift = {s_rx_burst, burst_q[BURST_LEN-1:1]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        remain_d   = remain_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        wait_cnt_d = wait_cnt_q;
        is_read_d  = is_read_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = addr_shift;
                    burst_d   = burst_shift;
                    is_read_d = s_read_en;
                    delay_d   = s_slave_delay;
                    cnt_d     = CW'(1);
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (s_master_valid) begin
                    addr_d  = addr_shift;
                    burst_d = burst_shift;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d      = '0;
                        wait_cnt_d = '0;
                        // A zero burst count still moves one word
                        remain_d   = (burst_shift == '0) ? BURST_LEN'(1) : burst_shift;
                        if (!is_read_q)
                            state_d = S_WDATA;
                        else if (delay_q == 6'd0)
                            state_d = S_FETCH;
                        else
                            state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WDATA: begin
                if (s_master_valid) begin
                    data_d = {s_rx_data, data_q[DATA_LEN-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WRITE: begin
                addr_d   = addr_q + ADDR_LEN'(1);
                remain_d = remain_q - BURST_LEN'(1);
                state_d  = (remain_q == BURST_LEN'(1)) ? S_IDLE : S_WDATA;
            end
            S_WAIT: begin
                if (wait_cnt_q == delay_q - 6'd1)
                    state_d = S_FETCH;
                else
                    wait_cnt_d = wait_cnt_q + 6'd1;
            end
            S_FETCH: begin
                data_d  = rd_data_q;
                cnt_d   = '0;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (s_master_ready) begin
                    data_d = {1'b0, data_q[DATA_LEN-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d    = '0;
                        addr_d   = addr_q + ADDR_LEN'(1);
                        remain_d = remain_q - BURST_LEN'(1);
                        state_d  = (remain_q == BURST_LEN'(1)) ? S_IDLE : S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            burst_q    <= '0;
            remain_q   <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            delay_q    <= '0;
            wait_cnt_q <= '0;
            is_read_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            remain_q   <= remain_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            wait_cnt_q <= wait_cnt_d;
            is_read_q  <= is_read_d;
        end
    end

    // Read port follows the next address so FETCH always sees the word it is about to load
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE)
            mem[addr_q] <= data_q;
        rd_data_q <= mem[addr_d];
    end

    assign s_slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign s_slave_valid = (state_q == S_RDATA);
    assign s_tx_data     = (state_q == S_RDATA) & data_q[0];

`ifdef SLAVE_SPLIT_EN
    localparam logic [5:0] SPLIT_TH = 6'(SPLIT_THRESHOLD);
    logic split_q, split_d;

    assign split_d = accept ? (s_slave_delay > SPLIT_TH) : split_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            split_q <= 1'b0;
        else
            split_q <= split_d;
    end

    assign s_split_en = (state_q == S_WAIT) && split_q;
`else
    assign s_split_en = 1'b0;
`endif

endmodule

// File: tb/tb_bus_slave_bram.sv
// Self-checking bench for bus_slave_bram: table of write/read-back transactions plus reset and request corner cases.
`timescale 1ns/1ps
module tb_bus_slave_bram;

    localparam int AL = 12;
    localparam int DL = 8;
`ifdef SLAVE_SPLIT_EN
    localparam int SPLIT_ON = 1;
`else
    localparam int SPLIT_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_master_valid = 1'b0;
    logic       s_master_ready = 1'b0;
    logic       s_write_en = 1'b0;
    logic       s_read_en = 1'b0;
    logic       s_rx_address = 1'b0;
    logic       s_rx_burst = 1'b0;
    logic       s_rx_data = 1'b0;
    logic [5:0] s_slave_delay = 6'd0;
    logic       s_slave_ready;
    logic       s_slave_valid;
    logic       s_tx_data;
    logic       s_split_en;

    bus_slave_bram dut (
        .clk            (clk),
        .reset          (reset),
        .s_master_valid (s_master_valid),
        .s_master_ready (s_master_ready),
        .s_write_en     (s_write_en),
        .s_read_en      (s_read_en),
        .s_rx_address   (s_rx_address),
        .s_rx_burst     (s_rx_burst),
        .s_rx_data      (s_rx_data),
        .s_slave_delay  (s_slave_delay),
        .s_slave_ready  (s_slave_ready),
        .s_slave_valid  (s_slave_valid),
        .s_tx_data      (s_tx_data),
        .s_split_en     (s_split_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [11:0] burst;
        logic [5:0]  delay;
        logic [7:0]  wd [3];
        bit          toggle;
        int          exp_lat;
        int          exp_split;
    } vec_t;

    vec_t       vecs [7];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model [int];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send_header(input bit is_read, input logic [11:0] addr, input logic [11:0] burst,
                               input logic [5:0] dly, input bit stalls);
        s_slave_delay = dly;
        for (int i = 0; i < AL; i++) begin
            if (stalls && i > 0 && $urandom_range(0, 3) == 0) begin
                s_master_valid = 1'b0;
                @(negedge clk);
            end
            s_master_valid = 1'b1;
            s_write_en     = !is_read;
            s_read_en      = is_read;
            s_rx_address   = addr[i];
            s_rx_burst     = burst[i];
            @(negedge clk);
        end
        s_master_valid = 1'b0;
        s_write_en     = 1'b0;
        s_read_en      = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input bit stalls);
        logic [7:0] w;
        int guard;
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
            for (int b = 0; b < DL; b++) begin
                guard = 0;
                while (!s_slave_ready && guard < 8) begin
                    s_master_valid = 1'b0;
                    @(negedge clk);
                    guard++;
                end
                if (stalls && $urandom_range(0, 3) == 0) begin
                    s_master_valid = 1'b0;
                    @(negedge clk);
                end
                s_master_valid = 1'b1;
                s_rx_data      = w[b];
                @(negedge clk);
            end
        end
        s_master_valid = 1'b0;
        guard = 0;
        while (!s_slave_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("write_cycle_len", guard, 1);
    endtask

    task automatic receive(input int n, input bit toggle, output int lat, output int split_cnt);
        int         cyc;
        int         got;
        int         bitcnt;
        bit         hold_pending;
        logic       held;
        logic [7:0] word;
        logic [7:0] exp_w;
        cyc = 0; got = 0; bitcnt = 0; lat = -1; split_cnt = 0;
        hold_pending = 1'b0; held = 1'b0; word = '0;
        while (got < n && cyc < 400) begin
            if (s_split_en) split_cnt++;
            if (s_slave_valid && lat < 0) lat = cyc;
            if (hold_pending) begin
                check("hold_bit", s_tx_data, held);
                hold_pending = 1'b0;
            end
            s_master_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (s_slave_valid) begin
                if (s_master_ready) begin
                    word[bitcnt] = s_tx_data;
                    bitcnt++;
                    if (bitcnt == DL) begin
                        exp_w = exp_q.pop_front();
                        check("read_word", word, exp_w);
                        bitcnt = 0;
                        got++;
                    end
                end else begin
                    hold_pending = 1'b1;
                    held         = s_tx_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (got < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_timeout: got %0d words, expected %0d", got, n);
            exp_q.delete();
        end
        check("idle_ready", s_slave_ready, 1);
        check("idle_valid", s_slave_valid, 0);
        s_master_ready = 1'b0;
    endtask

    task automatic read_back(input logic [11:0] addr, input logic [11:0] burst, input logic [5:0] dly,
                             input bit toggle, output int lat, output int sp);
        int n;
        n = (burst == 12'd0) ? 1 : int'(burst);
        for (int k = 0; k < n; k++)
            exp_q.push_back(model[(int'(addr) + k) % 4096]);
        send_header(1'b1, addr, burst, dly, 1'b1);
        receive(n, toggle, lat, sp);
    endtask

    initial begin
        int lat;
        int sp;
        int n;

        vecs[0] = '{12'h005, 12'd1, 6'd0,  '{8'hA5, 8'h00, 8'h00}, 1'b0, 1,  0};
        vecs[1] = '{12'hFFF, 12'd3, 6'd0,  '{8'h11, 8'h22, 8'h33}, 1'b0, 1,  0};
        vecs[2] = '{12'h123, 12'd1, 6'd5,  '{8'h5A, 8'h00, 8'h00}, 1'b1, 6,  0};
        vecs[3] = '{12'h200, 12'd2, 6'd10, '{8'hC3, 8'h3C, 8'h00}, 1'b0, 11, SPLIT_ON * 10};
        vecs[4] = '{12'h300, 12'd1, 6'd8,  '{8'h81, 8'h00, 8'h00}, 1'b0, 9,  0};
        vecs[5] = '{12'h050, 12'd0, 6'd2,  '{8'hE7, 8'h00, 8'h00}, 1'b1, 3,  0};
        vecs[6] = '{12'h010, 12'd1, 6'd1,  '{8'h3C, 8'h00, 8'h00}, 1'b0, 2,  0};

        repeat (3) @(negedge clk);
        check("reset_slave_ready", s_slave_ready, 1);
        check("reset_slave_valid", s_slave_valid, 0);
        check("reset_tx_data", s_tx_data, 0);
        check("reset_split_en", s_split_en, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            n = (vecs[v].burst == 12'd0) ? 1 : int'(vecs[v].burst);
            send_header(1'b0, vecs[v].addr, vecs[v].burst, 6'd0, 1'b1);
            send_words(n, vecs[v].wd[0], vecs[v].wd[1], vecs[v].wd[2], 1'b1);
            for (int k = 0; k < n; k++)
                model[(int'(vecs[v].addr) + k) % 4096] = vecs[v].wd[k];
            read_back(vecs[v].addr, vecs[v].burst, vecs[v].delay, vecs[v].toggle, lat, sp);
            check("read_latency", lat, vecs[v].exp_lat);
            check("split_cycles", sp, vecs[v].exp_split);
            $display("txn %0d: addr=0x%03h burst=%0d delay=%0d latency=%0d split_cycles=%0d",
                     v, vecs[v].addr, vecs[v].burst, vecs[v].delay, lat, sp);
        end

        // Separate single-word reads across the wrapped burst
        for (int k = 0; k < 3; k++) begin
            read_back(12'hFFF + 12'(k), 12'd1, 6'd0, 1'b0, lat, sp);
            check("wrap_read_latency", lat, 1);
            $display("txn wrap%0d: addr=0x%03h latency=%0d", k, 12'hFFF + 12'(k), lat);
        end

        // Both or neither request line: the request must be ignored
        s_master_valid = 1'b1; s_write_en = 1'b1; s_read_en = 1'b1; s_rx_address = 1'b1;
        @(negedge clk);
        s_write_en = 1'b0; s_read_en = 1'b0;
        @(negedge clk);
        s_master_valid = 1'b0;
        check("bad_req_ready", s_slave_ready, 1);
        read_back(12'h005, 12'd1, 6'd0, 1'b0, lat, sp);
        check("bad_req_latency", lat, 1);
        $display("txn bad_req: read 0x005 after ignored request, latency=%0d", lat);

        // Reset during the fourth data bit of a write must not disturb memory
        send_header(1'b0, 12'h010, 12'd1, 6'd0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            s_master_valid = 1'b1; s_rx_data = 1'b1;
            @(negedge clk);
        end
        s_master_valid = 1'b1; s_rx_data = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        check("abort_ready", s_slave_ready, 1);
        check("abort_valid", s_slave_valid, 0);
        reset = 1'b0;
        s_master_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", s_slave_ready, 1);
        read_back(12'h010, 12'd1, 6'd0, 1'b0, lat, sp);
        check("abort_latency", lat, 1);
        $display("txn abort: read 0x010 after aborted write, latency=%0d", lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_slave_bram.md
BUS_SLAVE_BRAM -- requirements
Module: bus_slave_bram

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 12, which sets the serial address width and gives a memory depth of 2**ADDR_LEN words.
REQ-002 SHALL have parameter DATA_LEN, default 8, the word width.
REQ-003 SHALL have parameter BURST_LEN, default 12, the serial burst-count width; BURST_LEN SHALL equal ADDR_LEN.
REQ-004 SHALL have parameter SPLIT_THRESHOLD, default 8, the delay above which a split is signalled.
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-high.
REQ-006 SHALL provide these ports, as name, direction, width, meaning:
- clk, in, 1, bus clock.
- reset, in, 1, async active-high reset.
- s_master_valid, in, 1, master driving address/data.
- s_master_ready, in, 1, master accepting read bits.
- s_write_en, in, 1, write request.
- s_read_en, in, 1, read request.
- s_rx_address, in, 1, serial address, LSB first.
- s_rx_burst, in, 1, serial burst count, LSB first.
- s_rx_data, in, 1, serial write data, LSB first.
- s_slave_delay, in, 6, read wait cycles.
- s_slave_ready, out, 1, slave accepting serial input.
- s_slave_valid, out, 1, s_tx_data valid.
- s_tx_data, out, 1, serial read data, LSB first.
- s_split_en, out, 1, split request.

Function
REQ-007 SHALL implement states IDLE, ADDR, WDATA, WRITE, WAIT, FETCH, RDATA.
REQ-008 IDLE SHALL have s_slave_ready=1 and SHALL accept a request when s_master_valid=1 and exactly one of s_write_en/s_read_en is 1; both or neither high SHALL leave it in IDLE.
REQ-009 The acceptance cycle SHALL capture address bit 0, burst bit 0, direction and s_slave_delay, then go to ADDR.
REQ-010 ADDR SHALL shift one address bit and one burst bit per cycle while s_master_valid=1, stall while 0, and exit after ADDR_LEN total bits: write to WDATA, read to WAIT.
REQ-011 Burst count B SHALL mean B words; B=0 SHALL be treated as 1.
REQ-012 WDATA SHALL have s_slave_ready=1 and shift s_rx_data one bit per cycle while s_master_valid=1, stalling while 0; after DATA_LEN bits it SHALL go to WRITE.
REQ-013 WRITE SHALL last exactly one cycle with s_slave_ready=0, write mem[addr], increment addr modulo 2**ADDR_LEN and decrement the remaining count, then go to WDATA, or to IDLE if the count reaches 0.
REQ-014 WAIT SHALL last exactly the latched delay D cycles, with D=0 going straight to FETCH; s_slave_ready=0.
REQ-015 FETCH SHALL last one cycle, load the shift register from mem[addr], and hold s_slave_valid=0.
REQ-016 RDATA SHALL hold s_slave_valid=1 and present the current bit on s_tx_data, starting with bit 0.
REQ-017 In RDATA the bit SHALL advance only in cycles with s_master_ready=1; after DATA_LEN accepted bits it SHALL increment addr modulo 2**ADDR_LEN, decrement the count, and go to FETCH, or to IDLE when the count reaches 0.
REQ-018 Address wrap from 2**ADDR_LEN-1 to 0 within a burst SHALL be silent.
REQ-019 Outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-020 Reset SHALL force IDLE with s_slave_ready=1, s_slave_valid=0, s_tx_data=0, s_split_en=0, and counters and shift registers cleared.
REQ-021 Reset asserted mid-transfer SHALL abort without a memory write; memory contents SHALL NOT be cleared.

Configuration
REQ-022 With SLAVE_SPLIT_EN defined, s_split_en SHALL be 1 during every WAIT cycle when latched D > SPLIT_THRESHOLD and 0 otherwise.
REQ-023 Without SLAVE_SPLIT_EN, s_split_en SHALL be constant 0 and all other behaviour SHALL be identical.

Verification
REQ-024 Write addr 0x005, burst 1, data 0xA5, then read 0x005 with D=0 -> s_tx_data bits 1,0,1,0,0,1,0,1; first bit one cycle after the last address bit.
REQ-025 Write burst 3 at 0xFFF with data 0x11, 0x22, 0x33 -> reads of 0xFFF, 0x000, 0x001 return 0x11, 0x22, 0x33.
REQ-026 Read with D=5 and s_master_ready toggling 1,0 -> s_slave_valid rises 6 cycles after the last address bit, and each bit is held during master_ready=0 cycles.
REQ-027 s_read_en=s_write_en=1 with s_master_valid=1 -> stays IDLE; reset asserted during the 4th data bit of a write to 0x010 -> mem[0x010] unchanged and IDLE next cycle.
REQ-028 With SLAVE_SPLIT_EN and D=10 -> s_split_en=1 for exactly 10 cycles; with D=8 it stays 0; without the macro it is always 0.
